// File: rtl/data_complement_pkg.sv
// Shared types and AXI constants for the read-complement-write burst controller.
package data_complement_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR_ADDR = 3'd3,
      ST_WR_DATA = 3'd4,
      ST_WR_RESP = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   localparam int unsigned BUF_DEPTH = 16;
   localparam int unsigned BUF_AW    = 4;
   localparam int unsigned BEAT_W    = 5;

endpackage

// File: rtl/data_complement_buf.sv
// Burst staging buffer: one synchronous write port, one asynchronous read port, no reset.
module data_complement_buf
   import data_complement_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [BUF_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [BUF_AW-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data_c
);

   logic [DATA_W-1:0] mem [BUF_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/data_complement_ctrl.sv
// AXI master that reads one burst, stores the bitwise complement of each beat,
// and writes the complemented burst back to a second address.
module data_complement_ctrl
   import data_complement_pkg::*;
#(
   parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned                   C_BURST_LEN        = 16,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_SRC_ADDR         = 32'h0000_0000,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_DST_ADDR         = 32'h0000_0040
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic                              INIT_AXI_TXN,
   output logic                              TXN_DONE,
   output logic                              ERROR,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     ARADDR,
   output logic [7:0]                        ARLEN,
   output logic [2:0]                        ARSIZE,
   output logic [1:0]                        ARBURST,
   output logic                              ARVALID,
   input  logic                              ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     RDATA,
   input  logic [1:0]                        RRESP,
   input  logic                              RLAST,
   input  logic                              RVALID,
   output logic                              RREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     AWADDR,
   output logic [7:0]                        AWLEN,
   output logic [2:0]                        AWSIZE,
   output logic [1:0]                        AWBURST,
   output logic                              AWVALID,
   input  logic                              AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   WSTRB,
   output logic                              WLAST,
   output logic                              WVALID,
   input  logic                              WREADY,
   input  logic [1:0]                        BRESP,
   input  logic                              BVALID,
   output logic                              BREADY
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_BURST_LEN - 1);

   state_t                        state, state_next;
   logic [BEAT_W-1:0]             beat_cnt, beat_next;
   logic                          init_q, armed;
   logic                          start_c;
   logic                          err_next;
   logic                          ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic                          last_beat;
   logic [C_M_AXI_DATA_WIDTH-1:0] buf_rdata;

   assign ARADDR  = C_SRC_ADDR;
   assign ARLEN   = 8'(C_BURST_LEN - 1);
   assign ARSIZE  = AXI_SIZE_4B;
   assign ARBURST = AXI_BURST_INCR;
   assign AWADDR  = C_DST_ADDR;
   assign AWLEN   = 8'(C_BURST_LEN - 1);
   assign AWSIZE  = AXI_SIZE_4B;
   assign AWBURST = AXI_BURST_INCR;
   assign WSTRB   = '1;

   // armed only after INIT has been seen low, so a level held through reset never starts a run
   assign start_c   = INIT_AXI_TXN & ~init_q & armed;
   assign ar_hs     = ARVALID & ARREADY;
   assign r_hs      = RVALID & RREADY;
   assign aw_hs     = AWVALID & AWREADY;
   assign w_hs      = WVALID & WREADY;
   assign b_hs      = BVALID & BREADY;
   assign last_beat = (beat_cnt == LAST_BEAT);

   data_complement_buf #(
      .DATA_W (C_M_AXI_DATA_WIDTH)
   ) u_buf (
      .clk       (ACLK),
      .wr_en     (r_hs),
      .wr_addr   (beat_cnt[BUF_AW-1:0]),
      .wr_data   (~RDATA),
      .rd_addr   (beat_next[BUF_AW-1:0]),
      .rd_data_c (buf_rdata)
   );

   // Next state, beat counter and sticky error
   always_comb begin
      state_next = state;
      beat_next  = beat_cnt;
      err_next   = ERROR;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start_c) begin
               state_next = ST_RD_ADDR;
               err_next   = 1'b0;
            end
         end
         ST_RD_ADDR: if (ar_hs) state_next = ST_RD_DATA;
         ST_RD_DATA: begin
            if (r_hs) begin
               beat_next = beat_cnt + BEAT_W'(1);
               if ((RRESP != AXI_RESP_OKAY) || (RLAST != last_beat)) err_next = 1'b1;
               if (last_beat) state_next = ST_WR_ADDR;
            end
         end
         ST_WR_ADDR: if (aw_hs) state_next = ST_WR_DATA;
         ST_WR_DATA: begin
            if (w_hs) begin
               beat_next = beat_cnt + BEAT_W'(1);
               if (last_beat) state_next = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            if (b_hs) begin
               state_next = ST_DONE;
               if (BRESP != AXI_RESP_OKAY) err_next = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (state_next != state) beat_next = '0;
   end

   // State register and registered AXI outputs, decoded from the next state
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state    <= ST_IDLE;
         beat_cnt <= '0;
         init_q   <= 1'b0;
         armed    <= 1'b0;
         ARVALID  <= 1'b0;
         RREADY   <= 1'b0;
         AWVALID  <= 1'b0;
         WVALID   <= 1'b0;
         WLAST    <= 1'b0;
         WDATA    <= '0;
         BREADY   <= 1'b0;
         TXN_DONE <= 1'b0;
         ERROR    <= 1'b0;
      end else begin
         state    <= state_next;
         beat_cnt <= beat_next;
         init_q   <= INIT_AXI_TXN;
         armed    <= armed | ~INIT_AXI_TXN;
         ARVALID  <= (state_next == ST_RD_ADDR);
         RREADY   <= (state_next == ST_RD_DATA);
         AWVALID  <= (state_next == ST_WR_ADDR);
         WVALID   <= (state_next == ST_WR_DATA);
         WLAST    <= (state_next == ST_WR_DATA) && (beat_next == LAST_BEAT);
         WDATA    <= buf_rdata;
         BREADY   <= (state_next == ST_WR_RESP);
         TXN_DONE <= (state_next == ST_DONE);
         ERROR    <= err_next;
      end
   end

endmodule

// File: doc/data_complement_ctrl.md
DATA_COMPLEMENT_CTRL -- requirements
Module: data_complement_ctrl

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width; only 32 is supported.
REQ-003 SHALL have parameter C_BURST_LEN, default 16, beats per burst; legal range 1..16.
REQ-004 SHALL have parameter C_SRC_ADDR, default 32'h0000_0000, read-burst base address.
REQ-005 SHALL have parameter C_DST_ADDR, default 32'h0000_0040, write-burst base address.
REQ-006 SHALL have port ACLK  in  1  single clock; all logic samples its rising edge.
REQ-007 SHALL have port ARESETN  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have port INIT_AXI_TXN  in  1  start request; acts on its rising edge.
REQ-009 SHALL have port TXN_DONE  out  1  sequence complete.
REQ-010 SHALL have port ERROR  out  1  sticky error flag.
REQ-011 SHALL have AR channel ports: ARADDR out ADDR_W, ARLEN out 8, ARSIZE out 3, ARBURST out 2, ARVALID out 1, ARREADY in 1.
REQ-012 SHALL have R channel ports: RDATA in 32, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1.
REQ-013 SHALL have AW channel ports: AWADDR out ADDR_W, AWLEN out 8, AWSIZE out 3, AWBURST out 2, AWVALID out 1, AWREADY in 1.
REQ-014 SHALL have W channel ports: WDATA out 32, WSTRB out 4, WLAST out 1, WVALID out 1, WREADY in 1.
REQ-015 SHALL have B channel ports: BRESP in 2, BVALID in 1, BREADY out 1.

Function
REQ-016 SHALL drive ARLEN/AWLEN = C_BURST_LEN-1, ARSIZE/AWSIZE = 3'b010, ARBURST/AWBURST = INCR (2'b01), and WSTRB = 4'hF, all as constants.
REQ-017 SHALL detect start by registering INIT_AXI_TXN; a start pulse is a 0->1 transition, accepted only in IDLE or DONE and ignored elsewhere.
REQ-018 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE.
REQ-019 SHALL transition IDLE/DONE -> RD_ADDR on start, clearing ERROR and TXN_DONE in that same cycle.
REQ-020 SHALL hold ARVALID high with ARADDR = C_SRC_ADDR in RD_ADDR and go to RD_DATA on the ARVALID&&ARREADY cycle.
REQ-021 SHALL hold RREADY high in RD_DATA; each RVALID&&RREADY beat stores ~RDATA into buffer[beat_cnt] and increments beat_cnt.
REQ-022 SHALL leave RD_DATA for WR_ADDR on the beat with beat_cnt = C_BURST_LEN-1.
REQ-023 SHALL set ERROR on any R beat with RRESP != 2'b00, or with RLAST inconsistent with beat_cnt = C_BURST_LEN-1; the transfer continues to completion regardless.
REQ-024 SHALL hold AWVALID high with AWADDR = C_DST_ADDR in WR_ADDR and go to WR_DATA on handshake; W SHALL NOT start before the AW handshake.
REQ-025 SHALL present WDATA = buffer[beat_cnt] with WVALID high in WR_DATA, advancing on WVALID&&WREADY; WLAST SHALL be high only on beat C_BURST_LEN-1.
REQ-026 SHALL go to WR_RESP after the last W handshake, hold BREADY high there, and go to DONE on BVALID.
REQ-027 SHALL set ERROR if BRESP != 2'b00.
REQ-028 SHALL hold TXN_DONE high in DONE until the next accepted start.
REQ-029 SHALL hold each VALID high, with stable payload, until the corresponding READY is seen.
REQ-030 SHALL support READY signals that are asserted early, never, or toggling, with no beat lost or duplicated.
REQ-031 SHALL clear beat_cnt on every state entry; beat_cnt SHALL be 5 bits wide.

Reset
REQ-032 SHALL, while ARESETN=0, drive all VALID/READY outputs, WLAST, TXN_DONE and ERROR to 0, set the FSM to IDLE, beat_cnt to 0 and the start-edge register to 0.
REQ-033 SHALL abandon any burst in flight when reset is asserted mid-operation, with outputs 0 asynchronously; the buffer contents are not reset.
REQ-034 SHALL leave IDLE only on a fresh rising edge after reset release; an INIT_AXI_TXN held high through reset SHALL NOT start a sequence.

Structure
REQ-035 SHALL take the FSM state encoding and the AXI burst, size and response constants (INCR, 4-byte size, OKAY) from shared package data_complement_pkg.
REQ-036 SHALL implement the 16x32 buffer as sub-module data_complement_buf: one synchronous write port, one asynchronous read port, no reset.

Verification
REQ-037 SHALL verify the basic sequence: slave memory at 0x00 holds 0x00abcdef,0x11111111,...,0xFFFFFFFF (16 beats), start -> memory at 0x40 holds 0xFF543210,0xEEEEEEEE,...,0x00000000; TXN_DONE=1; ERROR=0.
REQ-038 SHALL verify backpressure: random ARREADY/RVALID/AWREADY/WREADY/BVALID delays of 0-5 cycles -> identical memory result; exactly 16 R and 16 W handshakes; WLAST only on the 16th.
REQ-039 SHALL verify error reporting: RRESP=2'b10 on beat 3 -> ERROR=1 and TXN_DONE=1, all 16 writes still issued; a following start clears ERROR.
REQ-040 SHALL verify reset mid-burst: ARESETN low during WR_DATA beat 7 -> all VALIDs 0 within the same cycle, FSM IDLE; INIT_AXI_TXN held high -> no new sequence until it toggles.
REQ-041 SHALL verify start filtering: INIT_AXI_TXN toggled during RD_DATA -> ignored; exactly one AR and one AW per sequence.
